// File: rtl/fp_add_round_pipe.sv
// Significand add/subtract-with-rounding stage between alignment and normalisation.
// Per lane the rounding increment and the two's-complement +1 share a single carry-in.
// A beat reaches the output one cycle after it is accepted, unless it waits in the
// skid entry behind a stalled output. Beats of one thread can be flushed at any point.
module fp_add_round_pipe #(
    parameter int unsigned LANES        = 16,
    parameter int unsigned SIG_WIDTH    = 24,
    parameter int unsigned EXP_WIDTH    = 8,
    parameter int unsigned THREAD_WIDTH = 2,
    parameter int unsigned TAG_WIDTH    = 64
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [THREAD_WIDTH-1:0]          in_thread,
    input  logic [TAG_WIDTH-1:0]             in_tag,
    input  logic [LANES*SIG_WIDTH-1:0]       in_sig_le,
    input  logic [LANES*SIG_WIDTH-1:0]       in_sig_se,
    input  logic [LANES-1:0]                 in_subtract,
    input  logic [LANES-1:0]                 in_sign,
    input  logic [LANES*EXP_WIDTH-1:0]       in_exponent,
    input  logic [LANES*3-1:0]               in_grs,
    input  logic [1:0]                       round_mode,
    input  logic                             flush_en,
    input  logic [THREAD_WIDTH-1:0]          flush_thread,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [THREAD_WIDTH-1:0]          out_thread,
    output logic [TAG_WIDTH-1:0]             out_tag,
    output logic [LANES*(SIG_WIDTH+1)-1:0]   out_sum,
    output logic [LANES-1:0]                 out_sign,
    output logic [LANES*EXP_WIDTH-1:0]       out_exponent,
    output logic [LANES-1:0]                 out_subtract,
    output logic [LANES-1:0]                 out_tie
);

    localparam int unsigned SUM_WIDTH = SIG_WIDTH + 1;

    typedef struct packed {
        logic [THREAD_WIDTH-1:0]        thread;
        logic [TAG_WIDTH-1:0]           tag;
        logic [LANES*SUM_WIDTH-1:0]     sum;
        logic [LANES-1:0]               sign;
        logic [LANES*EXP_WIDTH-1:0]     exponent;
        logic [LANES-1:0]               subtract;
        logic [LANES-1:0]               tie;
    } beat_t;

    logic [LANES*SUM_WIDTH-1:0] lane_sum;
    logic [LANES-1:0]           lane_tie;
    beat_t                      in_beat;

    beat_t out_q, out_d;
    beat_t skid_q, skid_d;
    logic  out_vld_q, out_vld_d;
    logic  skid_vld_q, skid_vld_d;
    logic  in_ready_q, in_ready_d;

    logic flush_out, flush_skid, flush_in;
    logic out_live, skid_live, in_take, out_hold;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [SIG_WIDTH-1:0] le;
        logic [SIG_WIDTH-1:0] se;
        logic                 sub;
        logic                 sgn;
        logic                 g;
        logic                 r;
        logic                 s;
        logic                 inc;
        logic                 cin;

        assign le      = in_sig_le[l*SIG_WIDTH +: SIG_WIDTH];
        assign se      = in_sig_se[l*SIG_WIDTH +: SIG_WIDTH];
        assign sub     = in_subtract[l];
        assign sgn     = in_sign[l];
        assign {g, r, s} = in_grs[l*3 +: 3];

        // Rounding increment for the selected mode
        always_comb begin
            inc = 1'b0;
            case (round_mode)
                2'd0:    inc = g & (r | s);
                2'd1:    inc = 1'b0;
                2'd2:    inc = ~sgn & (g | r | s);
                default: inc = sgn & (g | r | s);
            endcase
        end

        // One adder: subtraction's +1 and the rounding increment meet in the carry-in
        assign cin = sub ^ inc;
        assign lane_sum[l*SUM_WIDTH +: SUM_WIDTH] =
            {1'b0, le} + ({1'b0, se} ^ {SUM_WIDTH{sub}}) + SUM_WIDTH'(cin);
        assign lane_tie[l] = (round_mode == 2'd0) & g & ~r & ~s;
    end

    // Assemble the beat computed from the current inputs
    always_comb begin
        in_beat          = '0;
        in_beat.thread   = in_thread;
        in_beat.tag      = in_tag;
        in_beat.sum      = lane_sum;
        in_beat.sign     = in_sign;
        in_beat.exponent = in_exponent;
        in_beat.subtract = in_subtract;
        in_beat.tie      = lane_tie;
    end

    // Flush qualification and handshake decode
    always_comb begin
        flush_out  = flush_en & (out_q.thread == flush_thread);
        flush_skid = flush_en & (skid_q.thread == flush_thread);
        flush_in   = flush_en & (in_thread == flush_thread);
        out_live   = out_vld_q & ~flush_out;
        skid_live  = skid_vld_q & ~flush_skid;
        in_take    = in_valid & in_ready_q & ~flush_in;
        out_hold   = out_live & ~out_ready;
    end

    // Next state: surviving beats keep arrival order, oldest lands in the output entry
    always_comb begin
        out_vld_d  = 1'b0;
        out_d      = out_q;
        skid_vld_d = 1'b0;
        skid_d     = skid_q;
        if (out_hold) begin
            out_vld_d = 1'b1;
            if (skid_live) begin
                skid_vld_d = 1'b1;
            end else if (in_take) begin
                skid_vld_d = 1'b1;
                skid_d     = in_beat;
            end
        end else if (skid_live) begin
            // in_ready is low whenever the skid entry is occupied, so no input competes here
            out_vld_d = 1'b1;
            out_d     = skid_q;
        end else if (in_take) begin
            out_vld_d = 1'b1;
            out_d     = in_beat;
        end
        in_ready_d = ~skid_vld_d;
    end

    // Output entry, skid entry and registered ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    // A squashed output beat is never presented
    assign out_valid    = out_vld_q & ~flush_out;
    assign in_ready     = in_ready_q;
    assign out_thread   = out_q.thread;
    assign out_tag      = out_q.tag;
    assign out_sum      = out_q.sum;
    assign out_sign     = out_q.sign;
    assign out_exponent = out_q.exponent;
    assign out_subtract = out_q.subtract;
    assign out_tie      = out_q.tie;

endmodule

// File: tb/tb_fp_add_round_pipe.sv
// Directed bench for fp_add_round_pipe: rounding vectors, flow control, flush and reset.
module tb_fp_add_round_pipe;

    localparam int unsigned LANES = 16;
    localparam int unsigned SW    = 24;
    localparam int unsigned EW    = 8;
    localparam int unsigned TW    = 2;
    localparam int unsigned GW    = 64;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [TW-1:0]           in_thread;
    logic [GW-1:0]           in_tag;
    logic [LANES*SW-1:0]     in_sig_le;
    logic [LANES*SW-1:0]     in_sig_se;
    logic [LANES-1:0]        in_subtract;
    logic [LANES-1:0]        in_sign;
    logic [LANES*EW-1:0]     in_exponent;
    logic [LANES*3-1:0]      in_grs;
    logic [1:0]              round_mode;
    logic                    flush_en;
    logic [TW-1:0]           flush_thread;
    logic                    out_valid;
    logic                    out_ready;
    logic [TW-1:0]           out_thread;
    logic [GW-1:0]           out_tag;
    logic [LANES*(SW+1)-1:0] out_sum;
    logic [LANES-1:0]        out_sign;
    logic [LANES*EW-1:0]     out_exponent;
    logic [LANES-1:0]        out_subtract;
    logic [LANES-1:0]        out_tie;

    int checks = 0;
    int errors = 0;

    fp_add_round_pipe dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_thread    (in_thread),
        .in_tag       (in_tag),
        .in_sig_le    (in_sig_le),
        .in_sig_se    (in_sig_se),
        .in_subtract  (in_subtract),
        .in_sign      (in_sign),
        .in_exponent  (in_exponent),
        .in_grs       (in_grs),
        .round_mode   (round_mode),
        .flush_en     (flush_en),
        .flush_thread (flush_thread),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_thread   (out_thread),
        .out_tag      (out_tag),
        .out_sum      (out_sum),
        .out_sign     (out_sign),
        .out_exponent (out_exponent),
        .out_subtract (out_subtract),
        .out_tie      (out_tie)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] le;
        logic [SW-1:0] se;
        logic          sub;
        logic          sign;
        logic [2:0]    grs;
        logic [1:0]    mode;
        logic [SW:0]   exp_sum;
        logic          exp_tie;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [TW-1:0] thr, input logic [GW-1:0] tag);
        in_valid  = 1'b1;
        in_thread = thr;
        in_tag    = tag;
    endtask

    // Reference: add gives le+se+inc, subtract gives le-se-inc, both modulo 2^(SW+1)
    function automatic logic [SW:0] ref_sum(input logic [SW-1:0] le, input logic [SW-1:0] se,
                                            input logic sub, input logic sgn,
                                            input logic [2:0] grs, input logic [1:0] mode);
        logic inc;
        logic any;
        any = |grs;
        case (mode)
            2'd0:    inc = grs[2] & (grs[1] | grs[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = ~sgn & any;
            default: inc = sgn & any;
        endcase
        if (sub) return (SW+1)'(le) - (SW+1)'(se) - (SW+1)'(inc);
        return (SW+1)'(le) + (SW+1)'(se) + (SW+1)'(inc);
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        logic [LANES*EW-1:0]      exp_e;
        logic [LANES*(SW+1)-1:0]  exp_sum_v;
        logic [LANES-1:0]         exp_tie_v;
        logic [225:0]             exp_pass;
        logic [SW-1:0]            le_r;
        logic [SW-1:0]            se_r;
        logic [2:0]               grs_r;
        logic                     sub_r;
        logic                     sgn_r;

        vecs[0]  = '{24'h800000, 24'h400000, 1'b0, 1'b0, 3'b000, 2'd0, 25'h0C00000, 1'b0};
        vecs[1]  = '{24'h800000, 24'h000001, 1'b1, 1'b0, 3'b000, 2'd0, 25'h07FFFFF, 1'b0};
        vecs[2]  = '{24'h800000, 24'h000001, 1'b1, 1'b0, 3'b110, 2'd0, 25'h07FFFFE, 1'b0};
        vecs[3]  = '{24'h800000, 24'h400000, 1'b0, 1'b0, 3'b110, 2'd0, 25'h0C00001, 1'b0};
        vecs[4]  = '{24'h800000, 24'h400000, 1'b0, 1'b0, 3'b110, 2'd1, 25'h0C00000, 1'b0};
        vecs[5]  = '{24'h800000, 24'h400000, 1'b0, 1'b1, 3'b110, 2'd2, 25'h0C00000, 1'b0};
        vecs[6]  = '{24'h800000, 24'h400000, 1'b0, 1'b1, 3'b110, 2'd3, 25'h0C00001, 1'b0};
        vecs[7]  = '{24'h800000, 24'h400000, 1'b0, 1'b0, 3'b100, 2'd0, 25'h0C00000, 1'b1};
        vecs[8]  = '{24'h800000, 24'h400000, 1'b0, 1'b0, 3'b001, 2'd2, 25'h0C00001, 1'b0};
        vecs[9]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 3'b110, 2'd0, 25'h1FFFFFF, 1'b0};
        vecs[10] = '{24'h800000, 24'h800000, 1'b1, 1'b0, 3'b111, 2'd0, 25'h1FFFFFF, 1'b0};
        vecs[11] = '{24'h800000, 24'h400000, 1'b0, 1'b0, 3'b111, 2'd3, 25'h0C00000, 1'b0};
        vecs[12] = '{24'h800000, 24'h400000, 1'b0, 1'b0, 3'b100, 2'd1, 25'h0C00000, 1'b0};

        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_thread    = '0;
        in_tag       = '0;
        in_sig_le    = '0;
        in_sig_se    = '0;
        in_subtract  = '0;
        in_sign      = '0;
        in_exponent  = '0;
        in_grs       = '0;
        round_mode   = 2'd0;
        flush_en     = 1'b0;
        flush_thread = '0;
        out_ready    = 1'b1;

        #12;
        chk("reset_out_valid", 512'(out_valid), 512'(0));
        chk("reset_in_ready", 512'(in_ready), 512'(1));
        chk("reset_out_sum", 512'(out_sum), 512'(0));
        chk("reset_out_tag", 512'(out_tag), 512'(0));
        reset_n = 1'b1;
        step();

        // Table vectors, broadcast to every lane
        for (int k = 0; k < 13; k++) begin
            for (int l = 0; l < int'(LANES); l++) exp_e[l*EW +: EW] = 8'(l*7 + k);
            in_sig_le   = {LANES{vecs[k].le}};
            in_sig_se   = {LANES{vecs[k].se}};
            in_subtract = {LANES{vecs[k].sub}};
            in_sign     = {LANES{vecs[k].sign}};
            in_grs      = {LANES{vecs[k].grs}};
            in_exponent = exp_e;
            round_mode  = vecs[k].mode;
            drive_beat(2'(k % 4), 64'(k + 16));
            step();
            exp_pass = {2'(k % 4), 64'(k + 16), {LANES{vecs[k].sign}}, {LANES{vecs[k].sub}}, exp_e};
            chk($sformatf("vec%0d_valid", k), 512'(out_valid), 512'(1));
            chk($sformatf("vec%0d_sum", k), 512'(out_sum), 512'({LANES{vecs[k].exp_sum}}));
            chk($sformatf("vec%0d_tie", k), 512'(out_tie), 512'({LANES{vecs[k].exp_tie}}));
            chk($sformatf("vec%0d_pass", k),
                512'({out_thread, out_tag, out_sign, out_subtract, out_exponent}), 512'(exp_pass));
        end
        in_valid = 1'b0;
        step();
        chk("idle_after_vectors", 512'(out_valid), 512'(0));

        // Independent random values per lane, one beat per rounding mode
        for (int m = 0; m < 4; m++) begin
            round_mode = 2'(m);
            for (int l = 0; l < int'(LANES); l++) begin
                le_r  = 24'h800000 | 24'($urandom_range(0, 32'h7FFFFF));
                se_r  = 24'($urandom) >> $urandom_range(0, 23);
                grs_r = 3'($urandom);
                sub_r = 1'($urandom);
                sgn_r = 1'($urandom);
                in_sig_le[l*SW +: SW] = le_r;
                in_sig_se[l*SW +: SW] = se_r;
                in_grs[l*3 +: 3]      = grs_r;
                in_subtract[l]        = sub_r;
                in_sign[l]            = sgn_r;
                exp_sum_v[l*(SW+1) +: SW+1] = ref_sum(le_r, se_r, sub_r, sgn_r, grs_r, 2'(m));
                exp_tie_v[l] = (m == 0) && (grs_r == 3'b100);
            end
            drive_beat(2'(m), 64'(m + 64));
            step();
            chk($sformatf("rand%0d_sum", m), 512'(out_sum), 512'(exp_sum_v));
            chk($sformatf("rand%0d_tie", m), 512'(out_tie), 512'(exp_tie_v));
        end
        in_valid = 1'b0;
        step();

        // Backpressure: three beats offered against a stalled output
        out_ready = 1'b0;
        drive_beat(2'd0, 64'd100);
        chk("bp_ready_initial", 512'(in_ready), 512'(1));
        step();
        chk("bp_a_valid", 512'(out_valid), 512'(1));
        chk("bp_a_tag", 512'(out_tag), 512'(100));
        drive_beat(2'd0, 64'd101);
        step();
        chk("bp_ready_low_skid_full", 512'(in_ready), 512'(0));
        chk("bp_a_held", 512'(out_tag), 512'(100));
        drive_beat(2'd0, 64'd102);
        step();
        chk("bp_ready_still_low", 512'(in_ready), 512'(0));
        chk("bp_a_held2", 512'({out_valid, out_tag}), 512'({1'b1, 64'd100}));
        out_ready = 1'b1;
        step();
        chk("bp_b_tag", 512'({out_valid, out_tag}), 512'({1'b1, 64'd101}));
        chk("bp_ready_back", 512'(in_ready), 512'(1));
        step();
        chk("bp_c_tag", 512'({out_valid, out_tag}), 512'({1'b1, 64'd102}));
        in_valid = 1'b0;
        step();
        chk("bp_drained", 512'(out_valid), 512'(0));

        // Flush the output entry's thread while the skid entry holds another thread
        out_ready = 1'b0;
        drive_beat(2'd1, 64'd200);
        step();
        drive_beat(2'd2, 64'd201);
        step();
        in_valid = 1'b0;
        chk("fl_skid_full", 512'(in_ready), 512'(0));
        flush_en     = 1'b1;
        flush_thread = 2'd1;
        #1;
        chk("fl_out_valid_masked", 512'(out_valid), 512'(0));
        step();
        flush_en = 1'b0;
        chk("fl_skid_promoted", 512'({out_valid, out_thread, out_tag}), 512'({1'b1, 2'd2, 64'd201}));
        chk("fl_ready_back", 512'(in_ready), 512'(1));

        // Flushed thread's input beat in the flush cycle is discarded
        out_ready    = 1'b1;
        flush_en     = 1'b1;
        flush_thread = 2'd1;
        drive_beat(2'd1, 64'd202);
        step();
        flush_en = 1'b0;
        chk("fl_input_dropped", 512'(out_valid), 512'(0));
        drive_beat(2'd3, 64'd203);
        step();
        chk("fl_next_beat", 512'({out_valid, out_thread, out_tag}), 512'({1'b1, 2'd3, 64'd203}));
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        flush_en     = 1'b1;
        flush_thread = 2'd2;
        #1;
        chk("fl_other_thread_visible", 512'(out_valid), 512'(1));
        step();
        flush_en = 1'b0;
        chk("fl_other_thread_kept", 512'({out_valid, out_tag}), 512'({1'b1, 64'd203}));
        out_ready = 1'b1;
        step();
        chk("fl_drained", 512'(out_valid), 512'(0));

        // Asynchronous reset with both entries occupied
        out_ready = 1'b0;
        drive_beat(2'd0, 64'd300);
        step();
        drive_beat(2'd1, 64'd301);
        step();
        in_valid = 1'b0;
        chk("rst_pre_full", 512'({out_valid, in_ready}), 512'({1'b1, 1'b0}));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_valid", 512'(out_valid), 512'(0));
        chk("rst_async_ready", 512'(in_ready), 512'(1));
        chk("rst_async_tag", 512'(out_tag), 512'(0));
        step();
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        chk("rst_no_stale1", 512'(out_valid), 512'(0));
        step();
        chk("rst_no_stale2", 512'({out_valid, in_ready}), 512'({1'b0, 1'b1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
